// File: rtl/dz_csr_scan_pkg.sv
// Shared CSR field positions, scanner states and the device-bus lane helper
// for the DZ multiplexer CSR/scanner.
package dz_csr_scan_pkg;

    localparam int CSR_TRDY  = 15;
    localparam int CSR_TIE   = 14;
    localparam int CSR_SA    = 13;
    localparam int CSR_SAE   = 12;
    localparam int CSR_TLN_H = 11;
    localparam int CSR_TLN_L = 8;
    localparam int CSR_RDONE = 7;
    localparam int CSR_RIE   = 6;
    localparam int CSR_MSE   = 5;
    localparam int CSR_CLR   = 4;
    localparam int CSR_MAINT = 3;

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } scan_state_t;

    // Device data is big-endian over 36 bits; bit 35 carries CSR bit 0.
    function automatic logic [15:0] csr_lane(input logic [0:35] d);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[k] = d[35-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/dz_csr_scan_oneshot.sv
// Reloadable down-counting one-shot; busy while the count is non-zero.
// Load wins over clear so a same-cycle restart is never lost.
module dz_oneshot #(
    parameter int COUNT = 750
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    output logic o_busy
);

    localparam int W = $clog2(COUNT) + 1;
    localparam logic [W-1:0] LOAD = W'(COUNT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/dz_csr_scan.sv
// DZ multiplexer CSR with round-robin transmit line scanner and
// gated TX/RX interrupt requests.
module dz_csr_scan
    import dz_csr_scan_pkg::*;
#(
    parameter int NLINES = 16,
    parameter int CLKFRQ = 50000000,
    parameter int CLR_US = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              devRESET,
    input  logic              devLOBYTE,
    input  logic              devHIBYTE,
    input  logic [0:35]       devDATAI,
    input  logic              csrWRITE,
    input  logic              tdrWRITE,
    input  logic              rbufRDONE,
    input  logic              rbufSA,
    input  logic [NLINES-1:0] uartTXEMPTY,
    input  logic [NLINES-1:0] tcrLIN,
    output logic [15:0]       regCSR,
    output logic              txINTR,
    output logic              rxINTR
);

    localparam int LW = $clog2(NLINES);
    localparam int CLR_CNT =
        int'((64'(CLR_US) * 64'(CLKFRQ)) / 64'd1000000);

    logic [15:0]   w_data;
    logic          w_clr;
    logic          w_force;
    logic          w_tdr_lo;
    logic          w_clr_load;
    logic          w_trdy;
    logic [3:0]    w_tline4;
    logic          w_unused;

    logic          r_tie;
    logic          r_sae;
    logic          r_rie;
    logic          r_mse;
    logic          r_maint;
    scan_state_t   r_state;
    logic [LW-1:0] r_scan;
    logic [LW-1:0] r_tline;

    assign w_data     = csr_lane(devDATAI);
    assign w_force    = w_clr | devRESET;
    assign w_tdr_lo   = tdrWRITE & devLOBYTE;
    assign w_clr_load = csrWRITE & devLOBYTE & w_data[CSR_CLR];
    assign w_unused   = ^{devDATAI[0:19], w_data[15], w_data[13],
                          w_data[11:7], w_data[2:0]};

    dz_oneshot #(
        .COUNT (CLR_CNT)
    ) u_clr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_clr_load),
        .i_clear (devRESET),
        .o_busy  (w_clr)
    );

    // A running clear discards writes, even ones landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tie   <= 1'b0;
            r_sae   <= 1'b0;
            r_rie   <= 1'b0;
            r_mse   <= 1'b0;
            r_maint <= 1'b0;
        end else if (w_force) begin
            r_tie   <= 1'b0;
            r_sae   <= 1'b0;
            r_rie   <= 1'b0;
            r_mse   <= 1'b0;
            r_maint <= 1'b0;
        end else if (csrWRITE) begin
            if (devHIBYTE) begin
                r_tie <= w_data[CSR_TIE];
                r_sae <= w_data[CSR_SAE];
            end
            if (devLOBYTE) begin
                r_rie   <= w_data[CSR_RIE];
                r_mse   <= w_data[CSR_MSE];
                r_maint <= w_data[CSR_MAINT];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SCAN;
            r_scan  <= '0;
            r_tline <= '0;
        end else if (w_force) begin
            r_state <= ST_SCAN;
            r_scan  <= '0;
            r_tline <= '0;
        end else begin
            unique case (r_state)
                ST_SCAN: begin
                    if (r_mse) begin
                        if (tcrLIN[r_scan] & uartTXEMPTY[r_scan]) begin
                            r_tline <= r_scan;
                            r_state <= ST_HOLD;
                        end else begin
                            r_scan <= r_scan + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!tcrLIN[r_tline] || !r_mse) begin
                        r_scan  <= r_tline + 1'b1;
                        r_state <= ST_SCAN;
                    end else if (w_tdr_lo) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Resume past the served line so every line gets a turn.
                    if (!w_tdr_lo) begin
                        r_scan  <= r_tline + 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    assign w_trdy   = (r_state != ST_SCAN);
    assign w_tline4 = 4'(r_tline);

    assign regCSR = {w_trdy, r_tie, rbufSA, r_sae, w_tline4,
                     rbufRDONE, r_rie, r_mse, w_clr, r_maint, 3'b000};

    assign txINTR = w_trdy & r_tie;
    assign rxINTR = r_rie & (r_sae ? rbufSA : rbufRDONE);

endmodule

// File: tb/tb_dz_csr_scan.sv
// Randomised and directed bench for dz_csr_scan at 16 and 8 lines,
// checked every cycle against a behavioural model.
module tb_dz_csr_scan;

    localparam int CLR_TICKS = 15 * 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        devRESET, devLOBYTE, devHIBYTE;
    logic        csrWRITE, tdrWRITE, rbufRDONE, rbufSA;
    logic [0:35] devDATAI;
    logic [15:0] wdat;
    logic [15:0] lin, txe;
    logic [15:0] csr16, csr8;
    logic        tx16, rx16, tx8, rx8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dz_csr_scan #(.NLINES(16), .CLKFRQ(50000000), .CLR_US(15)) u_dut16 (
        .clk(clk), .rst(rst), .devRESET(devRESET),
        .devLOBYTE(devLOBYTE), .devHIBYTE(devHIBYTE),
        .devDATAI(devDATAI), .csrWRITE(csrWRITE), .tdrWRITE(tdrWRITE),
        .rbufRDONE(rbufRDONE), .rbufSA(rbufSA),
        .uartTXEMPTY(txe), .tcrLIN(lin),
        .regCSR(csr16), .txINTR(tx16), .rxINTR(rx16)
    );

    dz_csr_scan #(.NLINES(8), .CLKFRQ(50000000), .CLR_US(15)) u_dut8 (
        .clk(clk), .rst(rst), .devRESET(devRESET),
        .devLOBYTE(devLOBYTE), .devHIBYTE(devHIBYTE),
        .devDATAI(devDATAI), .csrWRITE(csrWRITE), .tdrWRITE(tdrWRITE),
        .rbufRDONE(rbufRDONE), .rbufSA(rbufSA),
        .uartTXEMPTY(txe[7:0]), .tcrLIN(lin[7:0]),
        .regCSR(csr8), .txINTR(tx8), .rxINTR(rx8)
    );

    typedef struct {
        int clr;
        bit tie, sae, rie, mse, maint;
        bit granted, inwr;
        int scan, tline;
    } m_t;

    m_t m16, m8;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:35] pack(input logic [15:0] v);
        logic [0:35] d;
        d = '0;
        d[0:19] = 20'($urandom);
        for (int k = 0; k < 16; k++) d[35-k] = v[k];
        return d;
    endfunction

    function automatic m_t mstep(input m_t m, input int n);
        m_t r;
        bit frc, tlo;
        r = m;
        frc = (m.clr != 0) || devRESET;
        tlo = tdrWRITE && devLOBYTE;
        if (frc) begin
            r.granted = 0; r.inwr = 0; r.scan = 0; r.tline = 0;
        end else if (!m.granted) begin
            if (m.mse) begin
                if (lin[m.scan] && txe[m.scan]) begin
                    r.tline = m.scan; r.granted = 1;
                end else begin
                    r.scan = (m.scan + 1) % n;
                end
            end
        end else if (!m.inwr) begin
            if (!lin[m.tline] || !m.mse) begin
                r.granted = 0; r.scan = (m.tline + 1) % n;
            end else if (tlo) begin
                r.inwr = 1;
            end
        end else if (!tlo) begin
            r.granted = 0; r.inwr = 0; r.scan = (m.tline + 1) % n;
        end
        if (frc) begin
            r.tie = 0; r.sae = 0; r.rie = 0; r.mse = 0; r.maint = 0;
        end else if (csrWRITE) begin
            if (devHIBYTE) begin
                r.tie = wdat[14]; r.sae = wdat[12];
            end
            if (devLOBYTE) begin
                r.rie = wdat[6]; r.mse = wdat[5]; r.maint = wdat[3];
            end
        end
        if (csrWRITE && devLOBYTE && wdat[4]) r.clr = CLR_TICKS;
        else if (devRESET) r.clr = 0;
        else if (m.clr > 0) r.clr = m.clr - 1;
        return r;
    endfunction

    function automatic logic [15:0] mcsr(input m_t m);
        return {m.granted, m.tie, rbufSA, m.sae, 4'(m.tline),
                rbufRDONE, m.rie, m.mse, m.clr != 0, m.maint, 3'b000};
    endfunction

    function automatic logic mtx(input m_t m);
        return m.granted & m.tie;
    endfunction

    function automatic logic mrx(input m_t m);
        return m.rie & (m.sae ? rbufSA : rbufRDONE);
    endfunction

    task automatic tick();
        m16 = mstep(m16, 16);
        m8  = mstep(m8, 8);
        @(posedge clk);
        #1;
        chk("csr16", csr16, mcsr(m16));
        chk("tx16", tx16, mtx(m16));
        chk("rx16", rx16, mrx(m16));
        chk("csr8", csr8, mcsr(m8));
        chk("tx8", tx8, mtx(m8));
        chk("rx8", rx8, mrx(m8));
        chk("csr8_b11", csr8[11], 1'b0);
    endtask

    task automatic csr_wr(input bit lo, input bit hi, input logic [15:0] v);
        csrWRITE = 1; devLOBYTE = lo; devHIBYTE = hi;
        wdat = v; devDATAI = pack(v);
        tick();
        csrWRITE = 0; devLOBYTE = 0; devHIBYTE = 0;
    endtask

    task automatic tdr_wr(input int len);
        tdrWRITE = 1; devLOBYTE = 1;
        repeat (len) tick();
        tdrWRITE = 0; devLOBYTE = 0;
        tick();
    endtask

    task automatic wait_trdy(input bit eight, input int lim, output int lat);
        bit ok;
        ok = 0;
        lat = 0;
        for (int i = 0; i <= lim; i++) begin
            if (eight ? csr8[15] : csr16[15]) begin
                ok = 1; lat = i; break;
            end
            if (i < lim) tick();
        end
        chk("trdy_timeout", ok, 1'b1);
    endtask

    initial begin
        int cnt, lat;
        m16 = '{default: 0};
        m8  = '{default: 0};
        rst = 1; devRESET = 0; devLOBYTE = 0; devHIBYTE = 0;
        csrWRITE = 0; tdrWRITE = 0; rbufRDONE = 0; rbufSA = 0;
        wdat = '0; devDATAI = '0; lin = '0; txe = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_csr16", csr16, 16'h0000);
        chk("rst_csr8", csr8, 16'h0000);
        chk("rst_tx", tx16, 1'b0);
        chk("rst_rx", rx16, 1'b0);

        csr_wr(1, 1, 16'h0010);
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (csr16[4]) cnt++;
            if (i % 100 == 50 && i < 700) csr_wr(1, 1, 16'h4060);
            else tick();
        end
        chk("clr_len", cnt, CLR_TICKS);
        chk("clr_discard", csr16 & 16'h4060, 16'h0000);

        lin = 16'hFFFF; txe = 16'h8000;
        csr_wr(1, 0, 16'h0020);
        wait_trdy(0, 20, lat);
        chk("t2_lat", lat <= 16, 1'b1);
        chk("t2_tline", csr16[11:8], 4'hF);

        lin = 16'h0005; txe = 16'h0005;
        tick();
        for (int g = 0; g < 4; g++) begin
            wait_trdy(0, 20, lat);
            chk("t3_rr", csr16[11:8], (g % 2) ? 4'd2 : 4'd0);
            tdr_wr(3);
        end

        lin = 16'h0008; txe = 16'h0008;
        wait_trdy(0, 20, lat);
        chk("t4_tline", csr16[11:8], 4'd3);
        lin = 16'h0000; txe = 16'h0010;
        tick();
        chk("t4_drop", csr16[15], 1'b0);
        lin = 16'h0010;
        tick();
        chk("t4_resume", csr16[15:8], 8'h84);

        csr_wr(0, 1, 16'h4000);
        chk("t5_tx", tx16, 1'b1);
        rbufRDONE = 1; rbufSA = 0;
        csr_wr(1, 0, 16'h0060);
        chk("t5_rx_rdone", rx16, 1'b1);
        csr_wr(0, 1, 16'h5000);
        chk("t5_rx_sa", rx16, 1'b0);

        tdrWRITE = 1; devLOBYTE = 1;
        tick();
        chk("t6_wait", csr16[15], 1'b1);
        devRESET = 1; csrWRITE = 1; wdat = 16'h0070;
        devDATAI = pack(wdat);
        tick();
        chk("t6_scan", csr16[15], 1'b0);
        chk("t6_rw", csr16 & 16'h5068, 16'h0000);
        chk("t6_clr", csr16[4], 1'b1);
        devRESET = 0; csrWRITE = 0; tdrWRITE = 0; devLOBYTE = 0;
        repeat (760) tick();

        lin = 16'h0081; txe = 16'h0081;
        csr_wr(1, 0, 16'h0020);
        for (int g = 0; g < 4; g++) begin
            wait_trdy(1, 20, lat);
            chk("t7_rr8", csr8[11:8], (g % 2) ? 4'd7 : 4'd0);
            tdr_wr(2);
        end

        for (int i = 0; i < 3000; i++) begin
            csrWRITE = ($urandom % 16 == 0);
            devLOBYTE = 1'($urandom);
            devHIBYTE = 1'($urandom);
            if (csrWRITE) begin
                wdat = 16'($urandom);
                if ($urandom % 64 != 0) wdat[4] = 1'b0;
            end
            devDATAI = pack(wdat);
            if ($urandom % 4 == 0) tdrWRITE = ~tdrWRITE;
            devRESET = ($urandom % 64 == 0);
            rbufSA = 1'($urandom);
            rbufRDONE = 1'($urandom);
            if ($urandom % 8 == 0) lin = 16'($urandom) | 16'($urandom);
            if ($urandom % 8 == 0) txe = 16'($urandom) & 16'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
